// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_ctrl_pkg
// Description : Shared types and constants for the AES-128 key-schedule
//               controller and its round-robin read arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_ctrl_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        COLLECT = 2'd2,
        READY   = 2'd3
    } state_e;

    localparam int AES128_ROUNDS  = 10;
    localparam int RK_W           = 128;
    localparam int RIDX_W         = 4;
    localparam int WDOG_LIMIT_DEF = 63;

endpackage : aes_ctrl_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin arbiter. Grant is combinational from
//               req/en; the priority pointer is registered and flips to the
//               requester that was not granted, so contention alternates.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // r_prio = 0 favours requester 0 on contention, 1 favours requester 1
    logic r_prio;

    // One-hot grant selection; nothing granted when disabled
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = r_prio ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Move priority away from whoever was just served
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (gnt != 2'b00) begin
            r_prio <= gnt[0];
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_sched_ctrl
// Description : Starts the AES-128 key-expansion engine on each accepted
//               master key, captures the in-order round keys into a local
//               store, watchdogs the engine, and serves round-key reads to
//               the encrypt (0) and decrypt (1) cores through a round-robin
//               arbiter with a fixed one-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_sched_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS,
    parameter int WDOG_LIMIT = WDOG_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_load,
    input  logic [RK_W-1:0]   key_in,
    output logic              ke_start,
    output logic [RK_W-1:0]   ke_key,
    input  logic              ke_valid,
    input  logic [RIDX_W-1:0] ke_round,
    input  logic [RK_W-1:0]   ke_round_key,
    output logic              keys_ready,
    output logic              busy,
    input  logic [1:0]        req,
    input  logic [7:0]        req_round,
    output logic [1:0]        gnt,
    output logic              rk_valid,
    output logic [RK_W-1:0]   rk_out,
    output logic              rk_id,
    output logic [RIDX_W-1:0] rk_round,
    output logic              err
);

    localparam int WD_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [RIDX_W-1:0] C_LAST_ROUND = NUM_ROUNDS[RIDX_W-1:0];
    localparam logic [WD_W-1:0]   C_WDOG_LIMIT = WDOG_LIMIT[WD_W-1:0];

    state_e            r_state;
    state_e            w_state_nxt;
    logic [RIDX_W-1:0] r_exp_round;
    logic [WD_W-1:0]   r_wdog;
    logic [WD_W-1:0]   w_wdog_inc;
    logic [RK_W-1:0]   r_store [0:NUM_ROUNDS];

    logic              w_load_acc;
    logic              w_cap;
    logic              w_seq_err;
    logic              w_wdog_err;
    logic              w_arb_en;

    logic              w_rd_sel;
    logic              w_rd_any;
    logic [RIDX_W-1:0] w_rd_round;
    logic              w_rd_oor;

    assign w_wdog_inc = r_wdog + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load_acc  = 1'b0;
        w_cap       = 1'b0;
        w_seq_err   = 1'b0;
        w_wdog_err  = 1'b0;
        w_arb_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (key_load) begin
                    w_load_acc  = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_state_nxt = COLLECT;
            end
            COLLECT: begin
                if (ke_valid) begin
                    if (ke_round == r_exp_round) begin
                        w_cap = 1'b1;
                        if (r_exp_round == C_LAST_ROUND) begin
                            w_state_nxt = READY;
                        end
                    end else begin
                        w_seq_err   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else if (w_wdog_inc == C_WDOG_LIMIT) begin
                    w_wdog_err  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            READY: begin
                // Grants this cycle are honoured even if a reload is accepted
                w_arb_en = 1'b1;
                if (key_load) begin
                    w_load_acc  = 1'b1;
                    w_state_nxt = START;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ke_start   = (r_state == START);
    assign busy       = (r_state == START) || (r_state == COLLECT);
    assign keys_ready = (r_state == READY);

    // Expected-round counter and engine watchdog
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp_round <= '0;
            r_wdog      <= '0;
        end else if (r_state == START) begin
            r_exp_round <= '0;
            r_wdog      <= '0;
        end else if (w_cap) begin
            r_exp_round <= r_exp_round + 1'b1;
            r_wdog      <= '0;
        end else if (r_state == COLLECT) begin
            r_wdog      <= w_wdog_inc;
        end
    end

    // Key presented to the engine, latched on an accepted load
    always_ff @(posedge clk) begin
        if (rst) begin
            ke_key <= '0;
        end else if (w_load_acc) begin
            ke_key <= key_in;
        end
    end

    // Round-key store write port
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                r_store[i] <= '0;
            end
        end else if (w_cap) begin
            r_store[r_exp_round] <= ke_round_key;
        end
    end

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (w_arb_en),
        .req (req),
        .gnt (gnt)
    );

    assign w_rd_any   = |gnt;
    assign w_rd_sel   = gnt[1];
    assign w_rd_round = w_rd_sel ? req_round[7:4] : req_round[3:0];
    assign w_rd_oor   = w_rd_any && (w_rd_round > C_LAST_ROUND);

    // Registered read port: data appears the cycle after the grant
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_valid <= 1'b0;
            rk_out   <= '0;
            rk_id    <= 1'b0;
            rk_round <= '0;
        end else begin
            rk_valid <= w_rd_any;
            if (w_rd_any) begin
                rk_id    <= w_rd_sel;
                rk_round <= w_rd_round;
                rk_out   <= w_rd_oor ? '0 : r_store[w_rd_round];
            end else begin
                rk_id    <= 1'b0;
                rk_round <= '0;
                rk_out   <= '0;
            end
        end
    end

    // Sticky error; a fresh fault outranks the clear from a simultaneous load
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (w_seq_err || w_wdog_err || w_rd_oor) begin
            err <= 1'b1;
        end else if (w_load_acc) begin
            err <= 1'b0;
        end
    end

endmodule : aes_key_sched_ctrl
`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_sched_ctrl
// Description : Directed self-checking bench for aes_key_sched_ctrl. The
//               expansion engine is modelled by replaying the FIPS-197
//               Appendix A.1 round keys for key 2b7e1516...
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_sched_ctrl;

    logic         clk;
    logic         rst;
    logic         key_load;
    logic [127:0] key_in;
    logic         ke_start;
    logic [127:0] ke_key;
    logic         ke_valid;
    logic [3:0]   ke_round;
    logic [127:0] ke_round_key;
    logic         keys_ready;
    logic         busy;
    logic [1:0]   req;
    logic [7:0]   req_round;
    logic [1:0]   gnt;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic         rk_id;
    logic [3:0]   rk_round;
    logic         err;

    int n_checks;
    int n_fail;

    logic [127:0] rk_tab [0:10];
    logic [127:0] c_key;

    aes_key_sched_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .key_load     (key_load),
        .key_in       (key_in),
        .ke_start     (ke_start),
        .ke_key       (ke_key),
        .ke_valid     (ke_valid),
        .ke_round     (ke_round),
        .ke_round_key (ke_round_key),
        .keys_ready   (keys_ready),
        .busy         (busy),
        .req          (req),
        .req_round    (req_round),
        .gnt          (gnt),
        .rk_valid     (rk_valid),
        .rk_out       (rk_out),
        .rk_id        (rk_id),
        .rk_round     (rk_round),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Engine model: present one round-key strobe for one cycle
    task automatic emit(input int r);
        ke_valid     = 1'b1;
        ke_round     = r[3:0];
        ke_round_key = rk_tab[r];
        step();
        ke_valid     = 1'b0;
    endtask

    // Accept a load and step into COLLECT
    task automatic do_load(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        c_key     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_tab[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_tab[1] = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_tab[2] = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_tab[3] = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_tab[4] = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_tab[5] = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_tab[6] = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_tab[7] = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_tab[8] = 128'head27321b58dbad2312bf5607f8d292f;
        rk_tab[9] = 128'hac7766f319fadc2128d12941575c006e;
        rk_tab[10]= 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst = 1'b1; key_load = 1'b0; key_in = '0;
        ke_valid = 1'b0; ke_round = '0; ke_round_key = '0;
        req = 2'b00; req_round = 8'h00;
        step(); step(); step();

        // Reset state
        check_val("rst_ctrl", {ke_start, keys_ready, busy, gnt, rk_valid, rk_id, err}, '0);
        check_val("rst_ke_key", ke_key, '0);
        check_val("rst_rk_out", {rk_out, rk_round}, '0);
        rst = 1'b0;
        step();

        // FIPS-197 load: busy/ke_start/ke_key in T+1
        key_in   = c_key;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        check_val("load_busy", busy, 1'b1);
        check_val("load_ke_start", ke_start, 1'b1);
        check_val("load_ke_key", ke_key, c_key);
        check_val("load_kr", keys_ready, 1'b0);
        step();
        check_val("start_1cyc", ke_start, 1'b0);
        for (int r = 0; r <= 10; r++) emit(r);
        check_val("cap_kr", keys_ready, 1'b1);
        check_val("cap_busy", busy, 1'b0);
        check_val("cap_err", err, 1'b0);

        // Single read, round 1 by requester 0
        req = 2'b01; req_round = 8'h01;
        #1 check_val("rd1_gnt", gnt, 2'b01);
        step();
        req = 2'b00;
        check_val("rd1_data", {rk_valid, rk_id, rk_round, rk_out}, {1'b1, 1'b0, 4'd1, rk_tab[1]});

        // Single read, round 10 by requester 1
        req = 2'b10; req_round = 8'hA0;
        #1 check_val("rd10_gnt", gnt, 2'b10);
        step();
        req = 2'b00;
        check_val("rd10_data", {rk_valid, rk_id, rk_round, rk_out}, {1'b1, 1'b1, 4'd10, rk_tab[10]});

        // Contention: both held, requester 0 -> round 0, requester 1 -> round 10
        req = 2'b11; req_round = 8'hA0;
        for (int i = 0; i < 4; i++) begin
            #1 check_val($sformatf("rr_gnt%0d", i), gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            step();
            check_val($sformatf("rr_rd%0d", i), {rk_valid, rk_id, rk_out},
                      (i % 2 == 0) ? {1'b1, 1'b0, rk_tab[0]} : {1'b1, 1'b1, rk_tab[10]});
        end
        req = 2'b00;
        step();
        check_val("rr_idle", rk_valid, 1'b0);

        // Out-of-order engine: rounds 0,1,3
        do_load(c_key);
        emit(0); emit(1); emit(3);
        check_val("seq_err", {err, keys_ready, busy}, 3'b100);
        key_in = c_key; key_load = 1'b1;
        step();
        key_load = 1'b0;
        check_val("seq_clr", {err, busy}, 2'b01);
        step();

        // Engine stalls after round 4, requests held meanwhile
        for (int r = 0; r <= 4; r++) emit(r);
        req = 2'b11; req_round = 8'h00;
        for (int i = 0; i < 50; i++) step();
        check_val("wd_mid", {err, busy, gnt}, 4'b0100);
        for (int i = 0; i < 20; i++) step();
        check_val("wd_err", {err, busy, keys_ready, gnt}, 5'b10000);
        req = 2'b00;
        step();

        // key_load during COLLECT is ignored
        do_load(c_key);
        for (int r = 0; r <= 4; r++) emit(r);
        key_in = 128'hdeadbeef_00000000_11111111_22222222;
        key_load = 1'b1;
        emit(5);
        key_load = 1'b0;
        check_val("ign_start", {ke_start, busy}, 2'b01);
        check_val("ign_key", ke_key, c_key);
        for (int r = 6; r <= 10; r++) emit(r);
        check_val("ign_done", {keys_ready, err}, 2'b10);
        req = 2'b01; req_round = 8'h0A;
        step();
        req = 2'b00;
        check_val("ign_rd10", rk_out, rk_tab[10]);

        // Out-of-range read
        req = 2'b01; req_round = 8'h0C;
        #1 check_val("oor_gnt", gnt, 2'b01);
        step();
        req = 2'b00;
        check_val("oor_data", {rk_valid, rk_round, rk_out}, {1'b1, 4'd12, 128'h0});
        check_val("oor_err", err, 1'b1);

        // Reset in the middle of collection, then reload
        do_load(c_key);
        for (int r = 0; r <= 5; r++) emit(r);
        rst = 1'b1;
        step();
        check_val("midrst_ctrl", {ke_start, keys_ready, busy, gnt, rk_valid, rk_id, err}, '0);
        check_val("midrst_key", {ke_key, rk_out}, '0);
        rst = 1'b0;
        step();
        do_load(c_key);
        for (int r = 0; r <= 10; r++) emit(r);
        check_val("reload_kr", keys_ready, 1'b1);
        req = 2'b10; req_round = 8'hA0;
        step();
        req = 2'b00;
        check_val("reload_rd10", {rk_valid, rk_id, rk_out}, {1'b1, 1'b1, rk_tab[10]});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_aes_key_sched_ctrl
`default_nettype wire
